// File: rtl/text_console_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared constants and types for the teletype-style text console writer.
//   - Screen geometry (columns, rows, cells, bytes) for the 80x25 text mode
//   - Control codes the console reacts to (CR, LF, BS, FF)
//   - The writer state enumeration
//   - cell_index(): row/col to linear cell number
// -----------------------------------------------------------------------------
package text_pkg;

   localparam int COLS      = 80;
   localparam int ROWS      = 25;
   localparam int CELLS     = COLS * ROWS;   // 2000 character cells
   localparam int BYTES     = CELLS * 2;     // char + attribute per cell
   localparam int ROW_BYTES = COLS * 2;      // 160 bytes per screen row

   localparam logic [7:0] FILL_CHAR = 8'h20;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] BS = 8'h08;
   localparam logic [7:0] FF = 8'h0C;

   typedef enum logic [2:0] {
      IDLE,
      PUT_CHAR,
      PUT_ATTR,
      SCROLL_RD,
      SCROLL_WR,
      FILL,
      CLEAR
   } state_t;

   // Linear cell number seen by the display adapter: row*80 + col.
   function automatic logic [10:0] cell_index(input logic [4:0] row,
                                              input logic [6:0] col);
      return 11'(row) * 11'(COLS) + 11'(col);
   endfunction

endpackage

// File: rtl/text_console_if.sv
// -----------------------------------------------------------------------------
// text_console_if
// Bundles the byte-stream handshake, the video RAM write/read port and the
// exported cursor of the text console.
//   char_data/char_attr/char_valid  byte stream in (producer -> console)
//   char_ready                      console can take a byte
//   mem_address/mem_wdata/mem_we    video RAM port driven by the console
//   mem_rdata                       video RAM registered read data
//   cursor                          current cell index for the display adapter
// Modports:
//   master - producer / RAM side (drives bytes and read data)
//   slave  - the console itself
// -----------------------------------------------------------------------------
interface text_console_if;

   logic [7:0]  char_data;
   logic [7:0]  char_attr;
   logic        char_valid;
   logic        char_ready;
   logic [11:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic [10:0] cursor;

   modport master (
      output char_data, char_attr, char_valid, mem_rdata,
      input  char_ready, mem_address, mem_wdata, mem_we, cursor
   );

   modport slave (
      input  char_data, char_attr, char_valid, mem_rdata,
      output char_ready, mem_address, mem_wdata, mem_we, cursor
   );

endinterface

// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
// Teletype-style writer for the 80x25 text-mode video memory. Accepts bytes
// over a valid/ready handshake and writes char/attribute pairs (char at the
// even address, attribute at the odd one). Handles CR, LF, BS and FF, and
// scrolls the screen up one row when output runs past the last cell.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      text_console_if.slave: byte stream, video RAM port, cursor
// -----------------------------------------------------------------------------
module text_console
   import text_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   text_console_if.slave    bus
);

   state_t      state_q, state_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [10:0] cursor_q, cursor_d;
   logic [7:0]  attr_q, attr_d;
   logic        char_ready_q, char_ready_d;
   logic        mem_we_q, mem_we_d;
   logic [11:0] mem_address_q, mem_address_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        accept;

   assign accept = bus.char_valid && char_ready_q;

   assign bus.char_ready  = char_ready_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_address = mem_address_q;
   assign bus.cursor      = cursor_q;
   // The RAM read data only arrives during SCROLL_WR, so the copy path
   // bypasses the write-data register for that one state.
   assign bus.mem_wdata   = (state_q == SCROLL_WR) ? bus.mem_rdata : mem_wdata_q;

   // Next-state logic. mem_address_q doubles as the scroll/fill/clear
   // counter: in SCROLL_RD it holds the source byte, in SCROLL_WR the
   // destination (source - 160), and in FILL/CLEAR the byte being written.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      attr_d        = attr_q;
      char_ready_d  = char_ready_q;
      mem_we_d      = 1'b0;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               attr_d = bus.char_attr;
               case (bus.char_data)
                  CR: col_d = '0;
                  LF: begin
                     col_d = '0;
                     if (row_q == 5'(ROWS - 1)) begin
                        state_d       = SCROLL_RD;
                        char_ready_d  = 1'b0;
                        mem_address_d = 12'(ROW_BYTES);
                     end else begin
                        row_d = row_q + 5'd1;
                     end
                  end
                  BS: begin
                     if (col_q != '0) begin
                        col_d = col_q - 7'd1;
                     end else if (row_q != '0) begin
                        row_d = row_q - 5'd1;
                        col_d = 7'(COLS - 1);
                     end
                  end
                  FF: begin
                     state_d       = CLEAR;
                     char_ready_d  = 1'b0;
                     mem_we_d      = 1'b1;
                     mem_address_d = '0;
                     mem_wdata_d   = FILL_CHAR;
                  end
                  default: begin
                     state_d       = PUT_CHAR;
                     char_ready_d  = 1'b0;
                     mem_we_d      = 1'b1;
                     mem_address_d = {cursor_q, 1'b0};
                     mem_wdata_d   = bus.char_data;
                  end
               endcase
            end
         end

         PUT_CHAR: begin
            state_d       = PUT_ATTR;
            mem_we_d      = 1'b1;
            mem_address_d = mem_address_q + 12'd1;
            mem_wdata_d   = attr_q;
         end

         PUT_ATTR: begin
            if (col_q == 7'(COLS - 1)) begin
               col_d = '0;
               if (row_q == 5'(ROWS - 1)) begin
                  state_d       = SCROLL_RD;
                  mem_address_d = 12'(ROW_BYTES);
               end else begin
                  row_d        = row_q + 5'd1;
                  state_d      = IDLE;
                  char_ready_d = 1'b1;
               end
            end else begin
               col_d        = col_q + 7'd1;
               state_d      = IDLE;
               char_ready_d = 1'b1;
            end
         end

         SCROLL_RD: begin
            state_d       = SCROLL_WR;
            mem_we_d      = 1'b1;
            mem_address_d = mem_address_q - 12'(ROW_BYTES);
         end

         SCROLL_WR: begin
            if (mem_address_q == 12'(BYTES - ROW_BYTES - 1)) begin
               state_d       = FILL;
               mem_we_d      = 1'b1;
               mem_address_d = 12'(BYTES - ROW_BYTES);
               mem_wdata_d   = FILL_CHAR;
            end else begin
               state_d       = SCROLL_RD;
               mem_address_d = mem_address_q + 12'(ROW_BYTES + 1);
            end
         end

         FILL, CLEAR: begin
            if (mem_address_q == 12'(BYTES - 1)) begin
               state_d      = IDLE;
               char_ready_d = 1'b1;
               if (state_q == CLEAR) begin
                  row_d = '0;
                  col_d = '0;
               end
            end else begin
               mem_we_d      = 1'b1;
               mem_address_d = mem_address_q + 12'd1;
               // Next byte is odd (attribute) when the current one is even.
               mem_wdata_d   = mem_address_q[0] ? FILL_CHAR : attr_q;
            end
         end

         default: begin
            state_d      = IDLE;
            char_ready_d = 1'b1;
         end
      endcase

      cursor_d = cell_index(row_d, col_d);
   end

   // All state and registered outputs; reset aborts any scroll or clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         cursor_q      <= '0;
         attr_q        <= '0;
         char_ready_q  <= 1'b1;
         mem_we_q      <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         cursor_q      <= cursor_d;
         attr_q        <= attr_d;
         char_ready_q  <= char_ready_d;
         mem_we_q      <= mem_we_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_text_console.sv
// -----------------------------------------------------------------------------
// tb_text_console
// Directed bench for text_console: a 4 KB video RAM model with registered
// read, a byte sender and a linear sequence of checks with hand-derived
// expected values.
// -----------------------------------------------------------------------------
module tb_text_console;
   import text_pkg::*;

   logic clock = 1'b0;
   logic reset_n;

   text_console_if bus();

   text_console dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] vram [0:4095];
   logic [7:0] snap [0:3999];
   int wr_count = 0;
   int vectors = 0;
   int miscompares = 0;
   int low;
   int wr0;
   int errs;

   // Video RAM model: write port plus one-cycle registered read.
   always @(posedge clock) begin
      if (bus.mem_we) begin
         vram[bus.mem_address] <= bus.mem_wdata;
         wr_count <= wr_count + 1;
      end
      bus.mem_rdata <= vram[bus.mem_address];
   end

   // Safety net in case something stalls outside a bounded wait.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents one byte and returns 1 time unit after the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, input logic [7:0] a);
      int waited = 0;
      @(negedge clock);
      bus.char_data  = d;
      bus.char_attr  = a;
      bus.char_valid = 1'b1;
      while (bus.char_ready !== 1'b1 && waited < 20000) begin
         @(negedge clock);
         waited++;
      end
      if (waited >= 20000) checkOutput("accept_timeout", 32'(bus.char_ready), 1);
      @(posedge clock);
      #1;
      bus.char_valid = 1'b0;
   endtask

   // Counts cycles with char_ready low until it returns high.
   task automatic waitIdle(output int lowCycles);
      lowCycles = 0;
      @(negedge clock);
      while (bus.char_ready !== 1'b1 && lowCycles < 20000) begin
         lowCycles++;
         @(negedge clock);
      end
      if (lowCycles >= 20000) checkOutput("idle_timeout", 32'(bus.char_ready), 1);
   endtask

   task automatic takeSnapshot();
      for (int i = 0; i < 4000; i++) snap[i] = vram[i];
   endtask

   // Expected screen after one scroll: rows shifted up, last row filled.
   task automatic checkScroll(input string tag, input logic [7:0] fa);
      int bad = 0;
      for (int i = 0; i < 3840; i++) if (vram[i] !== snap[i + 160]) bad++;
      for (int i = 3840; i < 4000; i++)
         if (vram[i] !== (((i % 2) == 0) ? 8'h20 : fa)) bad++;
      checkOutput(tag, 32'(bad), 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.char_valid = 1'b0;
      bus.char_data  = '0;
      bus.char_attr  = '0;
      for (int i = 0; i < 4096; i++) vram[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_ready",   32'(bus.char_ready),  1);
      checkOutput("rst_we",      32'(bus.mem_we),      0);
      checkOutput("rst_address", 32'(bus.mem_address), 0);
      checkOutput("rst_wdata",   32'(bus.mem_wdata),   0);
      checkOutput("rst_cursor",  32'(bus.cursor),      0);
      reset_n = 1'b1;

      // 'A' with attribute 0x1F, cycle by cycle
      applyStimulus(8'h41, 8'h1F);
      @(negedge clock);
      checkOutput("putc_we",    32'(bus.mem_we),      1);
      checkOutput("putc_addr",  32'(bus.mem_address), 0);
      checkOutput("putc_wdata", 32'(bus.mem_wdata),   32'h41);
      checkOutput("putc_ready", 32'(bus.char_ready),  0);
      @(negedge clock);
      checkOutput("puta_we",    32'(bus.mem_we),      1);
      checkOutput("puta_addr",  32'(bus.mem_address), 1);
      checkOutput("puta_wdata", 32'(bus.mem_wdata),   32'h1F);
      @(negedge clock);
      checkOutput("a_ready",  32'(bus.char_ready), 1);
      checkOutput("a_cursor", 32'(bus.cursor),     1);
      checkOutput("a_we_off", 32'(bus.mem_we),     0);
      checkOutput("a_mem0",   32'(vram[0]),        32'h41);
      checkOutput("a_mem1",   32'(vram[1]),        32'h1F);

      // BS from cursor 1 back to 0, immediate
      applyStimulus(BS, 8'h00);
      waitIdle(low);
      checkOutput("bs1_low",    32'(low),        0);
      checkOutput("bs1_cursor", 32'(bus.cursor), 0);

      // 80 'x' back to back (valid held while busy), fills row 0
      wr0 = wr_count;
      for (int i = 0; i < 80; i++) applyStimulus(8'h78, 8'h07);
      waitIdle(low);
      checkOutput("x80_low",    32'(low),              2);
      checkOutput("x80_cursor", 32'(bus.cursor),       80);
      checkOutput("x80_writes", 32'(wr_count - wr0),   160);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (vram[i] !== (((i % 2) == 0) ? 8'h78 : 8'h07)) errs++;
      checkOutput("x80_row0", 32'(errs), 0);

      // CR at col 0 keeps 80; BS wraps to row 0 col 79; CR returns to 0
      applyStimulus(CR, 8'h00);
      waitIdle(low);
      checkOutput("cr_low",    32'(low),        0);
      checkOutput("cr_cursor", 32'(bus.cursor), 80);
      applyStimulus(BS, 8'h00);
      waitIdle(low);
      checkOutput("bs_wrap_cursor", 32'(bus.cursor), 79);
      applyStimulus(CR, 8'h00);
      waitIdle(low);
      checkOutput("cr_mid_cursor", 32'(bus.cursor), 0);

      // 24 LF to row 24, then 79 bytes to reach cell 1999
      for (int i = 0; i < 24; i++) applyStimulus(LF, 8'h00);
      waitIdle(low);
      checkOutput("lf24_cursor", 32'(bus.cursor), 1920);
      for (int i = 0; i < 79; i++) applyStimulus(8'h79, 8'h03);
      waitIdle(low);
      checkOutput("last_cell_cursor", 32'(bus.cursor), 1999);

      // Known pattern, then 'Z' in the last cell triggers a scroll
      for (int i = 0; i < 4000; i++) vram[i] = 8'(i * 7 + 3);
      takeSnapshot();
      snap[3998] = 8'h5A;
      snap[3999] = 8'h07;
      wr0 = wr_count;
      applyStimulus(8'h5A, 8'h07);
      waitIdle(low);
      checkOutput("z_ready_low", 32'(low),            7842);
      checkOutput("z_writes",    32'(wr_count - wr0), 4002);
      checkOutput("z_cursor",    32'(bus.cursor),     1920);
      checkOutput("z_row0_from_row1", 32'(vram[0]),   32'h63);
      checkOutput("z_cell1919_char",  32'(vram[3838]), 32'h5A);
      checkOutput("z_cell1919_attr",  32'(vram[3839]), 32'h07);
      checkOutput("z_fill_char",      32'(vram[3840]), 32'h20);
      checkOutput("z_fill_attr",      32'(vram[3999]), 32'h07);
      checkScroll("z_scroll_mem", 8'h07);

      // Row 24 col 5, LF scrolls
      for (int i = 0; i < 5; i++) applyStimulus(8'h6B, 8'h0A);
      waitIdle(low);
      checkOutput("k5_cursor", 32'(bus.cursor), 1925);
      takeSnapshot();
      wr0 = wr_count;
      applyStimulus(LF, 8'h4C);
      waitIdle(low);
      checkOutput("lf_ready_low", 32'(low),            7840);
      checkOutput("lf_writes",    32'(wr_count - wr0), 4000);
      checkOutput("lf_cursor",    32'(bus.cursor),     1920);
      checkScroll("lf_scroll_mem", 8'h4C);

      // FF clears the whole screen with attribute 0x1E
      wr0 = wr_count;
      applyStimulus(FF, 8'h1E);
      waitIdle(low);
      checkOutput("ff_ready_low", 32'(low),            4000);
      checkOutput("ff_writes",    32'(wr_count - wr0), 4000);
      checkOutput("ff_cursor",    32'(bus.cursor),     0);
      errs = 0;
      for (int i = 0; i < 4000; i++)
         if (vram[i] !== (((i % 2) == 0) ? 8'h20 : 8'h1E)) errs++;
      checkOutput("ff_mem", 32'(errs), 0);

      // BS at cursor 0 changes nothing and writes nothing
      wr0 = wr_count;
      applyStimulus(BS, 8'h00);
      waitIdle(low);
      checkOutput("bs0_cursor", 32'(bus.cursor),     0);
      checkOutput("bs0_writes", 32'(wr_count - wr0), 0);

      // Reset in the middle of a scroll
      for (int i = 0; i < 24; i++) applyStimulus(LF, 8'h00);
      applyStimulus(LF, 8'h00);
      repeat (1000) @(negedge clock);
      checkOutput("mid_scroll_busy", 32'(bus.char_ready), 0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_ready",   32'(bus.char_ready),  1);
      checkOutput("abort_we",      32'(bus.mem_we),      0);
      checkOutput("abort_address", 32'(bus.mem_address), 0);
      checkOutput("abort_wdata",   32'(bus.mem_wdata),   0);
      checkOutput("abort_cursor",  32'(bus.cursor),      0);
      @(negedge clock);
      reset_n = 1'b1;

      // First byte after reset lands at address 0
      applyStimulus(8'h42, 8'h2A);
      @(negedge clock);
      checkOutput("post_rst_we",    32'(bus.mem_we),      1);
      checkOutput("post_rst_addr",  32'(bus.mem_address), 0);
      checkOutput("post_rst_wdata", 32'(bus.mem_wdata),   32'h42);
      waitIdle(low);
      checkOutput("post_rst_mem0",   32'(vram[0]),    32'h42);
      checkOutput("post_rst_mem1",   32'(vram[1]),    32'h2A);
      checkOutput("post_rst_cursor", 32'(bus.cursor), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
